// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand fetch stage: register index, decoded instruction bundle, x0 index.
package operand_fetch_pkg;

  localparam int REG_ADDR_W = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef struct packed {
    logic      rs1_en;
    reg_addr_t rs1;
    logic      rs2_en;
    reg_addr_t rs2;
    logic      rd_en;
    reg_addr_t rd;
  } decoded_instr_t;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by issue and cleared by writeback.
module operand_fetch_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int DEPTH_LOG2 = REG_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       set_en,
  input  logic [DEPTH_LOG2-1:0]      set_addr,
  input  logic                       clr_en,
  input  logic [DEPTH_LOG2-1:0]      clr_addr,
  input  logic [2:0][DEPTH_LOG2-1:0] look_addr,
  output logic [2:0]                 look_busy
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [DEPTH-1:0] pending;

  // The set is written last so a new producer outranks a same-cycle writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      if (clr_en) pending[clr_addr] <= 1'b0;
      if (set_en && set_addr != '0) pending[set_addr] <= 1'b1;
    end
  end

  // A bit being cleared this cycle already counts as free.
  always_comb begin
    look_busy = '0;
    for (int i = 0; i < 3; i++) begin
      look_busy[i] = pending[look_addr[i]] && !(clr_en && clr_addr == look_addr[i]);
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: RAW/WAW scoreboard stalls, regfile read, one-cycle operand return.
// Define OPERAND_FETCH_BYPASS_EN to capture same-cycle writeback data instead of stalling.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_rs1_en,
  input  logic [DEPTH_LOG2-1:0] in_rs1_addr,
  input  logic                  in_rs2_en,
  input  logic [DEPTH_LOG2-1:0] in_rs2_addr,
  input  logic                  in_rd_en,
  input  logic [DEPTH_LOG2-1:0] in_rd_addr,
  output logic                  rf_rs1_read,
  output logic [DEPTH_LOG2-1:0] rf_rs1_addr,
  input  logic [WIDTH-1:0]      rf_rs1_rdata,
  output logic                  rf_rs2_read,
  output logic [DEPTH_LOG2-1:0] rf_rs2_addr,
  input  logic [WIDTH-1:0]      rf_rs2_rdata,
  input  logic                  wb_valid,
  input  logic [DEPTH_LOG2-1:0] wb_addr,
  input  logic [WIDTH-1:0]      wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_rs1_data,
  output logic [WIDTH-1:0]      out_rs2_data,
  output logic                  out_rd_en,
  output logic [DEPTH_LOG2-1:0] out_rd_addr
);

  function automatic logic s1_hit(input reg_addr_t a, input logic v, input logic en,
                                  input reg_addr_t rd);
    return v && en && rd == a;
  endfunction

  decoded_instr_t instr;
  assign instr = '{rs1_en: in_rs1_en, rs1: in_rs1_addr, rs2_en: in_rs2_en,
                   rs2: in_rs2_addr, rd_en: in_rd_en, rd: in_rd_addr};

  logic [2:0] sb_busy;
  logic       sb_set;
  assign sb_set = out_valid && out_ready && out_rd_en;

  operand_fetch_scoreboard #(.DEPTH_LOG2(DEPTH_LOG2)) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (sb_set),
    .set_addr  (out_rd_addr),
    .clr_en    (wb_valid),
    .clr_addr  (wb_addr),
    .look_addr ({instr.rd, instr.rs2, instr.rs1}),
    .look_busy (sb_busy)
  );

  logic rs1_live, rs2_live, rd_live, rs1_wb_hit, rs2_wb_hit, wb_live;
  assign rs1_live   = instr.rs1_en && instr.rs1 != REG_ZERO;
  assign rs2_live   = instr.rs2_en && instr.rs2 != REG_ZERO;
  assign rd_live    = instr.rd_en && instr.rd != REG_ZERO;
  assign wb_live    = wb_valid && wb_addr != REG_ZERO;
  assign rs1_wb_hit = wb_live && wb_addr == instr.rs1;
  assign rs2_wb_hit = wb_live && wb_addr == instr.rs2;

  logic hazard, accept;

  always_comb begin
    hazard = (rs1_live && (sb_busy[0] || s1_hit(instr.rs1, out_valid, out_rd_en, out_rd_addr)))
          || (rs2_live && (sb_busy[1] || s1_hit(instr.rs2, out_valid, out_rd_en, out_rd_addr)))
          || (rd_live  && (sb_busy[2] || s1_hit(instr.rd,  out_valid, out_rd_en, out_rd_addr)));
`ifdef OPERAND_FETCH_BYPASS_EN
`else
    // Without bypass the regfile would return the pre-write value, so wait a cycle.
    hazard = hazard || (rs1_live && rs1_wb_hit) || (rs2_live && rs2_wb_hit);
`endif
  end

  assign in_ready    = rst_n && !hazard && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign rf_rs1_read = accept && instr.rs1_en;
  assign rf_rs2_read = accept && instr.rs2_en;
  assign rf_rs1_addr = instr.rs1;
  assign rf_rs2_addr = instr.rs2;

  logic             fresh, rs1_use, rs2_use;
  logic [WIDTH-1:0] rs1_hold, rs2_hold, rs1_val, rs2_val;
`ifdef OPERAND_FETCH_BYPASS_EN
  logic             rs1_byp, rs2_byp;
  logic [WIDTH-1:0] byp_data;
`else
  logic             unused_wb_data;
  assign unused_wb_data = ^wb_data;
`endif

  // fresh marks the first output cycle, when regfile data is live; later cycles replay the hold regs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      fresh       <= 1'b0;
      rs1_use     <= 1'b0;
      rs2_use     <= 1'b0;
      out_rd_en   <= 1'b0;
      out_rd_addr <= '0;
      rs1_hold    <= '0;
      rs2_hold    <= '0;
`ifdef OPERAND_FETCH_BYPASS_EN
      rs1_byp     <= 1'b0;
      rs2_byp     <= 1'b0;
      byp_data    <= '0;
`endif
    end else begin
      out_valid <= accept || (out_valid && !out_ready);
      fresh     <= accept;
      if (accept) begin
        rs1_use     <= rs1_live;
        rs2_use     <= rs2_live;
        out_rd_en   <= rd_live;
        out_rd_addr <= instr.rd;
`ifdef OPERAND_FETCH_BYPASS_EN
        rs1_byp     <= rs1_wb_hit;
        rs2_byp     <= rs2_wb_hit;
        byp_data    <= wb_data;
`endif
      end
      if (fresh) begin
        rs1_hold <= rs1_val;
        rs2_hold <= rs2_val;
      end
    end
  end

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_use) rs1_val = rf_rs1_rdata;
    if (rs2_use) rs2_val = rf_rs2_rdata;
`ifdef OPERAND_FETCH_BYPASS_EN
    if (rs1_use && rs1_byp) rs1_val = byp_data;
    if (rs2_use && rs2_byp) rs2_val = byp_data;
`endif
  end

  assign out_rs1_data = fresh ? rs1_val : rs1_hold;
  assign out_rs2_data = fresh ? rs2_val : rs2_hold;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus random traffic against a behavioural model.
module tb_operand_fetch;

  localparam int W  = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, preload;
  logic          in_valid, in_ready, in_rs1_en, in_rs2_en, in_rd_en;
  logic [AW-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic          rf_rs1_read, rf_rs2_read;
  logic [AW-1:0] rf_rs1_addr, rf_rs2_addr;
  logic [W-1:0]  rf_rs1_rdata, rf_rs2_rdata;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic          out_valid, out_ready, out_rd_en;
  logic [W-1:0]  out_rs1_data, out_rs2_data;
  logic [AW-1:0] out_rd_addr;

  int n_checks = 0;
  int n_errors = 0;

  operand_fetch #(.WIDTH(W), .DEPTH_LOG2(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_en(in_rs1_en), .in_rs1_addr(in_rs1_addr),
    .in_rs2_en(in_rs2_en), .in_rs2_addr(in_rs2_addr),
    .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
    .rf_rs1_read(rf_rs1_read), .rf_rs1_addr(rf_rs1_addr), .rf_rs1_rdata(rf_rs1_rdata),
    .rf_rs2_read(rf_rs2_read), .rf_rs2_addr(rf_rs2_addr), .rf_rs2_rdata(rf_rs2_rdata),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd_en(out_rd_en), .out_rd_addr(out_rd_addr)
  );

  // Register file: synchronous read returns the value from before a same-edge write.
  logic [W-1:0] regs [16];

  function automatic logic [W-1:0] initVal(input int i);
    if (i == 3) return 32'h11;
    if (i == 5) return 32'h22;
    return 32'h100 * i;
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) regs[i] <= initVal(i);
      rf_rs1_rdata <= '0;
      rf_rs2_rdata <= '0;
    end else begin
      if (rf_rs1_read) rf_rs1_rdata <= regs[rf_rs1_addr];
      if (rf_rs2_read) rf_rs2_rdata <= regs[rf_rs2_addr];
      if (wb_valid && wb_addr != 0) regs[wb_addr] <= wb_data;
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending set, the single in-flight instruction and its operands.
  logic          m_valid = 1'b0, m_rd_en = 1'b0, m_zero = 1'b1;
  logic [W-1:0]  m_rs1 = '0, m_rs2 = '0;
  logic [AW-1:0] m_rd_addr = '0;
  logic [15:0]   m_pend = '0;
  logic          n_valid = 1'b0, n_rd_en = 1'b0, n_zero = 1'b1;
  logic [W-1:0]  n_rs1 = '0, n_rs2 = '0;
  logic [AW-1:0] n_rd_addr = '0;
  logic [15:0]   n_pend = '0;

  function automatic logic wbHits(input logic [AW-1:0] a);
    return wb_valid && wb_addr == a && a != 0;
  endfunction

  function automatic logic busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    return (m_pend[a] && !wbHits(a)) || (m_valid && m_rd_en && m_rd_addr == a);
  endfunction

  function automatic logic [W-1:0] curVal(input logic [AW-1:0] a);
    if (a == 0) return '0;
    return wbHits(a) ? wb_data : regs[a];
  endfunction

  always @(negedge clk) begin
    logic haz, rdy, acc;
    haz = (in_rs1_en && busy(in_rs1_addr)) || (in_rs2_en && busy(in_rs2_addr))
       || (in_rd_en && busy(in_rd_addr));
`ifdef OPERAND_FETCH_BYPASS_EN
`else
    haz = haz || (in_rs1_en && wbHits(in_rs1_addr)) || (in_rs2_en && wbHits(in_rs2_addr));
`endif
    rdy = rst_n && !haz && (!m_valid || out_ready);
    acc = in_valid && rdy;
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    checkOutput("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    if (m_valid || m_zero) begin
      checkOutput("out_rs1_data", out_rs1_data, m_rs1);
      checkOutput("out_rs2_data", out_rs2_data, m_rs2);
      checkOutput("out_rd_en", {31'b0, out_rd_en}, {31'b0, m_rd_en});
      checkOutput("out_rd_addr", {28'b0, out_rd_addr}, {28'b0, m_rd_addr});
    end
    checkOutput("rf_rs1_read", {31'b0, rf_rs1_read}, {31'b0, acc && in_rs1_en});
    checkOutput("rf_rs2_read", {31'b0, rf_rs2_read}, {31'b0, acc && in_rs2_en});
    if (acc && in_rs1_en) checkOutput("rf_rs1_addr", {28'b0, rf_rs1_addr}, {28'b0, in_rs1_addr});
    if (acc && in_rs2_en) checkOutput("rf_rs2_addr", {28'b0, rf_rs2_addr}, {28'b0, in_rs2_addr});

    n_pend = m_pend;
    if (wb_valid) n_pend[wb_addr] = 1'b0;
    if (m_valid && out_ready && m_rd_en) n_pend[m_rd_addr] = 1'b1;
    n_pend[0] = 1'b0;
    n_valid   = acc || (m_valid && !out_ready);
    n_zero    = m_zero && !acc;
    n_rs1     = m_rs1;
    n_rs2     = m_rs2;
    n_rd_en   = m_rd_en;
    n_rd_addr = m_rd_addr;
    if (acc) begin
      n_rs1     = in_rs1_en ? curVal(in_rs1_addr) : '0;
      n_rs2     = in_rs2_en ? curVal(in_rs2_addr) : '0;
      n_rd_en   = in_rd_en && in_rd_addr != 0;
      n_rd_addr = in_rd_addr;
    end
    if (!rst_n) begin
      n_pend = '0; n_valid = 1'b0; n_zero = 1'b1;
      n_rs1 = '0; n_rs2 = '0; n_rd_en = 1'b0; n_rd_addr = '0;
    end
  end

  always @(posedge clk) begin
    m_pend = n_pend; m_valid = n_valid; m_zero = n_zero;
    m_rs1 = n_rs1; m_rs2 = n_rs2; m_rd_en = n_rd_en; m_rd_addr = n_rd_addr;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic r1e, input logic [AW-1:0] r1,
                               input logic r2e, input logic [AW-1:0] r2,
                               input logic rde, input logic [AW-1:0] rd);
    in_valid = v; in_rs1_en = r1e; in_rs1_addr = r1; in_rs2_en = r2e; in_rs2_addr = r2;
    in_rd_en = rde; in_rd_addr = rd;
  endtask

  task automatic setWb(input logic v, input logic [AW-1:0] a, input logic [W-1:0] d);
    wb_valid = v; wb_addr = a; wb_data = d;
  endtask

  initial begin
    rst_n = 1'b0; preload = 1'b1; out_ready = 1'b1;
    setWb(0, 0, 0);
    applyStimulus(1, 1, 3, 1, 5, 0, 0);
    cycle(); cycle();
    preload = 1'b0;
    @(negedge clk);
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("reset in_ready", {31'b0, in_ready}, 32'h0);
    checkOutput("reset rf_rs1_read", {31'b0, rf_rs1_read}, 32'h0);
    checkOutput("reset out_rs1_data", out_rs1_data, 32'h0);
    checkOutput("reset out_rd_en", {31'b0, out_rd_en}, 32'h0);

    // First read: rs1=3, rs2=5.
    cycle(); rst_n = 1'b1;
    @(negedge clk);
    checkOutput("first in_ready", {31'b0, in_ready}, 32'h1);
    checkOutput("first rf_rs1_read", {31'b0, rf_rs1_read}, 32'h1);
    checkOutput("first rf_rs2_addr", {28'b0, rf_rs2_addr}, 32'h5);
    cycle(); in_valid = 1'b0;
    @(negedge clk);
    checkOutput("first out_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("first out_rs1", out_rs1_data, 32'h11);
    checkOutput("first out_rs2", out_rs2_data, 32'h22);

    // RAW on x4 waits for its writeback.
    cycle(); applyStimulus(1, 0, 0, 0, 0, 1, 4);
    @(negedge clk); checkOutput("A accepted", {31'b0, in_ready}, 32'h1);
    cycle(); applyStimulus(1, 1, 4, 0, 0, 0, 0);
    @(negedge clk); checkOutput("B stall s1", {31'b0, in_ready}, 32'h0);
    cycle();
    @(negedge clk); checkOutput("B stall sb", {31'b0, in_ready}, 32'h0);
    cycle(); setWb(1, 4, 32'h44);
`ifdef OPERAND_FETCH_BYPASS_EN
    @(negedge clk); checkOutput("B accept on wb", {31'b0, in_ready}, 32'h1);
    cycle(); in_valid = 1'b0; setWb(0, 0, 0);
`else
    @(negedge clk); checkOutput("B stall on wb", {31'b0, in_ready}, 32'h0);
    cycle(); setWb(0, 0, 0);
    @(negedge clk); checkOutput("B accept after wb", {31'b0, in_ready}, 32'h1);
    cycle(); in_valid = 1'b0;
`endif
    @(negedge clk); checkOutput("B out_rs1", out_rs1_data, 32'h44);

    // Writeback coinciding with the read of x7.
    cycle(); applyStimulus(1, 0, 0, 1, 7, 0, 0); setWb(1, 7, 32'hDEAD);
`ifdef OPERAND_FETCH_BYPASS_EN
    @(negedge clk); checkOutput("byp in_ready", {31'b0, in_ready}, 32'h1);
    cycle(); in_valid = 1'b0; setWb(0, 0, 0);
`else
    @(negedge clk); checkOutput("nobyp stall", {31'b0, in_ready}, 32'h0);
    cycle(); setWb(0, 0, 0);
    @(negedge clk); checkOutput("nobyp accept", {31'b0, in_ready}, 32'h1);
    cycle(); in_valid = 1'b0;
`endif
    @(negedge clk); checkOutput("byp out_rs2", out_rs2_data, 32'hDEAD);

    // Downstream back-pressure holds the operands and blocks new reads.
    cycle(); applyStimulus(1, 1, 3, 0, 0, 0, 0); out_ready = 1'b0;
    @(negedge clk); checkOutput("stall accept", {31'b0, in_ready}, 32'h1);
    cycle(); applyStimulus(1, 1, 5, 1, 3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall out_valid", {31'b0, out_valid}, 32'h1);
      checkOutput("stall out_rs1", out_rs1_data, 32'h11);
      checkOutput("stall in_ready", {31'b0, in_ready}, 32'h0);
      checkOutput("stall rf_rs1_read", {31'b0, rf_rs1_read}, 32'h0);
      cycle();
    end
    out_ready = 1'b1;
    @(negedge clk); checkOutput("unstall in_ready", {31'b0, in_ready}, 32'h1);
    cycle(); in_valid = 1'b0;
    @(negedge clk);
    checkOutput("unstall out_rs1", out_rs1_data, 32'h22);
    checkOutput("unstall out_rs2", out_rs2_data, 32'h11);

    // x0 source and destination; writeback to x0.
    cycle(); applyStimulus(1, 1, 0, 0, 0, 1, 0); setWb(1, 0, 32'h55);
    @(negedge clk); checkOutput("x0 in_ready", {31'b0, in_ready}, 32'h1);
    cycle(); in_valid = 1'b0; setWb(0, 0, 0);
    @(negedge clk);
    checkOutput("x0 out_rs1", out_rs1_data, 32'h0);
    checkOutput("x0 out_rd_en", {31'b0, out_rd_en}, 32'h0);

    // Issue and writeback of x6 in the same cycle leaves x6 pending; reset clears it.
    cycle(); applyStimulus(1, 0, 0, 0, 0, 1, 6);
    @(negedge clk); checkOutput("x6 producer accept", {31'b0, in_ready}, 32'h1);
    cycle(); in_valid = 1'b0; setWb(1, 6, 32'h66);
    @(negedge clk); checkOutput("x6 out_rd_addr", {28'b0, out_rd_addr}, 32'h6);
    cycle(); setWb(0, 0, 0); applyStimulus(1, 1, 6, 0, 0, 0, 0);
    @(negedge clk); checkOutput("x6 set wins", {31'b0, in_ready}, 32'h0);
    cycle();
    @(negedge clk); checkOutput("x6 still pending", {31'b0, in_ready}, 32'h0);
    cycle(); rst_n = 1'b0;
    @(negedge clk); checkOutput("mid reset in_ready", {31'b0, in_ready}, 32'h0);
    cycle(); rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post reset out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("post reset sb clear", {31'b0, in_ready}, 32'h1);
    cycle(); in_valid = 1'b0;
    @(negedge clk); checkOutput("post reset x6 read", out_rs1_data, 32'h66);

    // Random traffic over a small register window to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      cycle();
      rst_n     = ($urandom_range(0, 199) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus($urandom_range(0, 9) < 7,
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) != 0) begin
        int pick;
        pick = $urandom_range(0, 7);
        if (m_pend != 0 && $urandom_range(0, 3) != 0) begin
          int start;
          start = $urandom_range(0, 15);
          for (int k = 0; k < 16; k++) begin
            if (m_pend[(start + k) % 16]) begin
              pick = (start + k) % 16;
              break;
            end
          end
        end
        setWb(1, 4'(pick), $urandom);
      end else begin
        setWb(0, 0, 0);
      end
    end
    cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
